// File: rtl/acl2_frame_seq.sv
// ADXL362 register-frame sequencer for the PmodACL2 SPI path.
// Emits command, address and data bytes MSB first and captures read bytes into a small buffer.
module acl2_frame_seq #(
  parameter int         MAX_BYTES = 8,
  parameter logic [7:0] CMD_READ  = 8'h0B,
  parameter logic [7:0] CMD_WRITE = 8'h0A
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       req,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [3:0] len,
  input  logic [7:0] wdata,
  input  logic       miso_i,
  output logic       mosi_o,
  output logic       cs_n,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] rx_count,
  input  logic [2:0] rd_index,
  output logic [7:0] rd_data
);

  localparam int         IW   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [3:0] MAXB = 4'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

  state_t        state, state_nx;
  logic [2:0]    bc;
  logic [IW-1:0] byte_idx;
  logic [7:0]    rs;
  logic          rw_q;
  logic [7:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [3:0]    len_q;
  logic [7:0]    rbuf [MAX_BYTES];
  logic [7:0]    cur_byte;
  logic          len_ok;
  logic          last_byte;

  // Writes always carry exactly one byte, so their length field is don't-care.
  assign len_ok    = !rw || ((len != 4'd0) && (len <= MAXB));
  assign last_byte = ({{(4-IW){1'b0}}, byte_idx} == (len_q - 4'd1));

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cs_n     = 1'b1;
    cur_byte = '0;
    mosi_o   = 1'b0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE: begin
        if (req && len_ok) state_nx = CMD;
      end
      CMD: begin
        cs_n     = 1'b0;
        cur_byte = rw_q ? CMD_READ : CMD_WRITE;
        if (bc == 3'd7) state_nx = ADDR;
      end
      ADDR: begin
        cs_n     = 1'b0;
        cur_byte = addr_q;
        if (bc == 3'd7) state_nx = DATA;
      end
      DATA: begin
        cs_n     = 1'b0;
        cur_byte = rw_q ? 8'h00 : wdata_q;
        if ((bc == 3'd7) && (!rw_q || last_byte)) state_nx = DONE;
      end
      DONE: begin
        if (!req) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!cs_n) mosi_o = cur_byte[3'd7 - bc];
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      bc       <= '0;
      byte_idx <= '0;
      rs       <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      len_q    <= '0;
      err      <= 1'b0;
      rx_count <= '0;
      for (int unsigned i = 0; i < MAX_BYTES; i++) rbuf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (len_ok) begin
              rw_q     <= rw;
              addr_q   <= addr;
              wdata_q  <= wdata;
              len_q    <= rw ? len : 4'd1;
              err      <= 1'b0;
              bc       <= '0;
              byte_idx <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        CMD, ADDR: bc <= bc + 3'd1;
        DATA: begin
          bc <= bc + 3'd1;
          if (rw_q) begin
            rs <= {rs[6:0], miso_i};
            if (bc == 3'd7) begin
              rbuf[byte_idx] <= {rs[6:0], miso_i};
              byte_idx       <= byte_idx + IW'(1);
              if (last_byte) rx_count <= len_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data = ({1'b0, rd_index} < MAXB) ? rbuf[rd_index[IW-1:0]] : '0;

endmodule

// File: tb/tb_acl2_frame_seq.sv
// Directed bench for acl2_frame_seq: read/write frames, bad lengths, max burst, handshake, async reset.
module tb_acl2_frame_seq;

  logic       sclk = 1'b0;
  logic       rst;
  logic       req;
  logic       rw;
  logic [7:0] addr;
  logic [3:0] len;
  logic [7:0] wdata;
  logic       miso_i;
  logic       mosi_o;
  logic       cs_n;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] rx_count;
  logic [2:0] rd_index;
  logic [7:0] rd_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] mbyte [10];
  logic [7:0] mis   [8];
  int         low;

  acl2_frame_seq #(.MAX_BYTES(8), .CMD_READ(8'h0B), .CMD_WRITE(8'h0A)) dut (
    .sclk(sclk), .rst(rst), .req(req), .rw(rw), .addr(addr), .len(len),
    .wdata(wdata), .miso_i(miso_i), .mosi_o(mosi_o), .cs_n(cs_n), .busy(busy),
    .done(done), .err(err), .rx_count(rx_count), .rd_index(rd_index), .rd_data(rd_data)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues a request and runs until done, recording mosi bytes and cs_n-low cycles.
  task automatic frame(input logic r, input logic [7:0] a, input logic [3:0] l, input logic [7:0] wd);
    @(negedge sclk);
    req = 1'b1; rw = r; addr = a; len = l; wdata = wd; miso_i = 1'b0;
    low = 0;
    for (int i = 0; i < 10; i++) mbyte[i] = 8'h00;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge sclk);
      if (done) break;
      if (!cs_n) begin
        if (low < 80) mbyte[low / 8][7 - (low % 8)] = mosi_o;
        if (low >= 16 && low < 80) miso_i = mis[(low - 16) / 8][7 - ((low - 16) % 8)];
        else miso_i = 1'b0;
        low++;
      end
    end
    chk("done_reached", done, 1);
    chk("cs_n_in_done", cs_n, 1);
    chk("mosi_in_done", mosi_o, 0);
  endtask

  task automatic release_req();
    @(negedge sclk);
    req = 1'b0;
    @(negedge sclk);
    chk("done_drop", done, 0);
    chk("busy_drop", busy, 0);
  endtask

  task automatic rd(input logic [2:0] idx, input logic [7:0] exp, input string tag);
    rd_index = idx;
    #1;
    chk(tag, rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; len = '0; wdata = '0;
    miso_i = 1'b0; rd_index = '0;
    for (int i = 0; i < 8; i++) mis[i] = 8'h00;
    repeat (2) @(negedge sclk);
    rst = 1'b0;
    @(negedge sclk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_mosi", mosi_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rx_count", rx_count, 0);

    // Read of 3 bytes from 0x08
    mis[0] = 8'hA5; mis[1] = 8'h3C; mis[2] = 8'hF0;
    frame(1'b1, 8'h08, 4'd3, 8'h77);
    chk("rd_cmd", mbyte[0], 8'h0B);
    chk("rd_addr", mbyte[1], 8'h08);
    chk("rd_d0", mbyte[2], 8'h00);
    chk("rd_d1", mbyte[3], 8'h00);
    chk("rd_d2", mbyte[4], 8'h00);
    chk("rd_cs_low", low, 40);
    chk("rd_rx_count", rx_count, 3);
    rd(3'd0, 8'hA5, "rd_buf0");
    rd(3'd1, 8'h3C, "rd_buf1");
    rd(3'd2, 8'hF0, "rd_buf2");
    release_req();

    // Single-byte write leaves read state untouched
    frame(1'b0, 8'h2D, 4'd0, 8'h02);
    chk("wr_cmd", mbyte[0], 8'h0A);
    chk("wr_addr", mbyte[1], 8'h2D);
    chk("wr_data", mbyte[2], 8'h02);
    chk("wr_cs_low", low, 24);
    chk("wr_rx_count", rx_count, 3);
    rd(3'd0, 8'hA5, "wr_buf0");
    rd(3'd1, 8'h3C, "wr_buf1");
    rd(3'd2, 8'hF0, "wr_buf2");
    release_req();

    // Bad lengths: len=0 then len=9
    @(negedge sclk);
    req = 1'b1; rw = 1'b1; len = 4'd0; addr = 8'h00;
    repeat (3) @(negedge sclk);
    chk("bad0_err", err, 1);
    chk("bad0_cs_n", cs_n, 1);
    chk("bad0_busy", busy, 0);
    len = 4'd9;
    repeat (3) @(negedge sclk);
    chk("bad9_err", err, 1);
    chk("bad9_cs_n", cs_n, 1);
    chk("bad9_busy", busy, 0);
    chk("bad9_mosi", mosi_o, 0);
    req = 1'b0;
    repeat (2) @(negedge sclk);
    chk("bad_err_sticky", err, 1);

    // Max burst; acceptance clears err
    for (int i = 0; i < 8; i++) mis[i] = 8'(i + 1);
    frame(1'b1, 8'h0E, 4'd8, 8'h00);
    chk("max_err_clr", err, 0);
    chk("max_cs_low", low, 80);
    chk("max_rx_count", rx_count, 8);
    for (int i = 0; i < 8; i++) rd(3'(i), 8'(i + 1), "max_buf");

    // Held req in DONE: no second frame
    begin
      int bad_cyc;
      bad_cyc = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge sclk);
        if (done !== 1'b1 || cs_n !== 1'b1) bad_cyc++;
      end
      chk("hold_done_cycles_bad", bad_cyc, 0);
    end
    release_req();
    repeat (3) @(negedge sclk);
    chk("idle_cs_n", cs_n, 1);
    chk("idle_busy", busy, 0);

    // Async reset in the middle of a 4-byte read
    @(negedge sclk);
    req = 1'b1; rw = 1'b1; len = 4'd4; addr = 8'h10;
    repeat (30) @(negedge sclk);
    chk("pre_rst_cs_n", cs_n, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cs_n", cs_n, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_rx_count", rx_count, 0);
    chk("arst_mosi", mosi_o, 0);
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, "arst_buf");
    req = 1'b0;
    @(negedge sclk);
    rst = 1'b0;
    repeat (2) @(negedge sclk);
    chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
